// File: rtl/clk_div_bank.sv
// clk_div_bank: PLL-side divider bank with a lock-qualified system reset.
// NCH runtime-programmable dividers, each with a registered square output
// and a one-cycle tick. Divisor changes are applied only at a period
// boundary, or immediately on a resync, so clk_out and tick never glitch.
// Optional build macro CLKDIV_LOCK_REARM_EN: a loss of lock after release
// pulls n_rst_out low again and re-runs the full lock qualification.
module clk_div_bank #(
    parameter int                   NCH        = 4,
    parameter int                   DIV_W      = 8,
    parameter int                   CH_W       = 2,
    parameter logic [NCH*DIV_W-1:0] DIV_INIT   = {NCH{8'd2}},
    parameter int                   RST_CYCLES = 255
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             lock,
    input  logic             resync,
    input  logic             wr_en,
    input  logic [CH_W-1:0]  wr_ch,
    input  logic [DIV_W-1:0] wr_div,
    output logic             n_rst_out,
    output logic [NCH-1:0]   clk_out,
    output logic [NCH-1:0]   tick,
    output logic [NCH-1:0]   upd_pend
);

    localparam logic [15:0] SEQ_LAST = 16'(RST_CYCLES);

    logic [15:0] seq_cnt;
    logic        run_q;
    logic        start;

    // Lock qualification: count consecutive lock-high cycles, release once.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            seq_cnt   <= '0;
            n_rst_out <= 1'b0;
        end else if (n_rst_out) begin
`ifdef CLKDIV_LOCK_REARM_EN
            if (!lock) begin
                n_rst_out <= 1'b0;
                seq_cnt   <= '0;
            end
`endif
        end else if (!lock) begin
            seq_cnt <= '0;
        end else if (seq_cnt == SEQ_LAST) begin
            n_rst_out <= 1'b1;
        end else begin
            seq_cnt <= seq_cnt + 16'd1;
        end
    end

    // Remember whether channels were running last cycle, to spot the first
    // cycle after release (which starts every channel at count 0).
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            run_q <= 1'b0;
        end else begin
            run_q <= n_rst_out;
        end
    end

    // A start edge (first running cycle, or resync) aligns all channels.
    assign start = n_rst_out && (resync || !run_q);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        localparam logic [DIV_W-1:0] INIT = DIV_INIT[i*DIV_W +: DIV_W];

        logic [DIV_W-1:0] act_div;
        logic [DIV_W-1:0] pnd_div;
        logic [DIV_W-1:0] cnt;
        logic             pend_q;
        logic             clk_q;
        logic             tick_q;

        logic [DIV_W-1:0] act_nxt;
        logic [DIV_W-1:0] cnt_nxt;
        logic [DIV_W:0]   half;
        logic             apply;
        logic             wr_hit;
        logic             clk_nxt;
        logic             tick_nxt;

        // Indices at or above NCH never match a channel, so they are dropped.
        assign wr_hit = wr_en && (wr_ch == CH_W'(i));

        // Next count, divisor hand-over and output levels for this channel.
        // A held channel has no running period, so a pending divisor is taken
        // straight away; pnd_div equals act_div whenever nothing is pending,
        // which lets a start edge load it unconditionally.
        always_comb begin
            apply    = 1'b0;
            cnt_nxt  = '0;
            clk_nxt  = 1'b0;
            tick_nxt = 1'b0;
            if (!n_rst_out) begin
                apply = pend_q;
            end else if (start) begin
                apply = 1'b1;
            end else if (act_div == '0) begin
                apply = pend_q;
            end else if (cnt == act_div - DIV_W'(1)) begin
                apply = pend_q;
            end else begin
                cnt_nxt = cnt + DIV_W'(1);
            end
            act_nxt = apply ? pnd_div : act_div;
            half    = ({1'b0, act_nxt} + (DIV_W+1)'(1)) >> 1;
            if (n_rst_out && (act_nxt != '0)) begin
                tick_nxt = (cnt_nxt == '0);
                clk_nxt  = ({1'b0, cnt_nxt} < half);
            end
        end

        // Channel state; a same-cycle write re-arms the pending flag after
        // the older pending value has been consumed.
        always_ff @(posedge clk or negedge n_reset) begin
            if (!n_reset) begin
                act_div <= INIT;
                pnd_div <= INIT;
                cnt     <= '0;
                pend_q  <= 1'b0;
                clk_q   <= 1'b0;
                tick_q  <= 1'b0;
            end else begin
                act_div <= act_nxt;
                cnt     <= cnt_nxt;
                clk_q   <= clk_nxt;
                tick_q  <= tick_nxt;
                if (wr_hit) begin
                    pnd_div <= wr_div;
                    pend_q  <= 1'b1;
                end else if (apply) begin
                    pend_q  <= 1'b0;
                end
            end
        end

        assign clk_out[i]  = clk_q;
        assign tick[i]     = tick_q;
        assign upd_pend[i] = pend_q;
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// tb_clk_div_bank: randomized and directed bench for clk_div_bank with a
// phase-based reference model (period position per channel, integer math).
// Honours CLKDIV_LOCK_REARM_EN in the lock-loss section.
module tb_clk_div_bank;

    localparam int NCH   = 4;
    localparam int DIV_W = 8;
    localparam int CH_W  = 3;
    localparam int RST   = 255;

    logic             clk = 1'b0;
    logic             n_reset = 1'b0;
    logic             lock = 1'b0;
    logic             resync = 1'b0;
    logic             wr_en = 1'b0;
    logic [CH_W-1:0]  wr_ch = '0;
    logic [DIV_W-1:0] wr_div = '0;
    logic             n_rst_out;
    logic [NCH-1:0]   clk_out;
    logic [NCH-1:0]   tick;
    logic [NCH-1:0]   upd_pend;

    int n_total = 0;
    int n_bad   = 0;

    clk_div_bank #(
        .NCH(NCH), .DIV_W(DIV_W), .CH_W(CH_W),
        .DIV_INIT({NCH{8'd2}}), .RST_CYCLES(RST)
    ) dut (
        .clk(clk), .n_reset(n_reset), .lock(lock), .resync(resync),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_div(wr_div),
        .n_rst_out(n_rst_out), .clk_out(clk_out), .tick(tick),
        .upd_pend(upd_pend)
    );

    always #5 clk = ~clk;

    // reference model state
    bit             m_rel, m_run;
    int             m_seq;
    int             mN[NCH], mP[NCH], mph[NCH];
    bit             mpf[NCH];
    logic [NCH-1:0] e_clk, e_tick, e_pend;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_rel = 0; m_run = 0; m_seq = 0;
        for (int c = 0; c < NCH; c++) begin
            mN[c] = 2; mP[c] = 2; mph[c] = 0; mpf[c] = 0;
        end
        e_clk = '0; e_tick = '0; e_pend = '0;
    endtask

    task automatic model_step();
        bit rel0, st, wr;
        rel0 = m_rel;
        if (m_rel) begin
`ifdef CLKDIV_LOCK_REARM_EN
            if (!lock) begin m_rel = 0; m_seq = 0; end
`endif
        end else if (!lock) m_seq = 0;
        else if (m_seq == RST) m_rel = 1;
        else m_seq++;
        st = rel0 && (resync || !m_run);
        for (int c = 0; c < NCH; c++) begin
            wr = wr_en && (int'(wr_ch) == c);
            if (!rel0 || st || mN[c] == 0) begin
                if (mpf[c] || st) begin mN[c] = mP[c]; mpf[c] = 0; end
                mph[c] = 0;
            end else begin
                mph[c] = (mph[c] + 1) % mN[c];
                if (mph[c] == 0 && mpf[c]) begin mN[c] = mP[c]; mpf[c] = 0; end
            end
            if (wr) begin mP[c] = int'(wr_div); mpf[c] = 1; end
            e_tick[c] = rel0 && mN[c] >= 1 && mph[c] == 0;
            e_clk[c]  = rel0 && mN[c] >= 1 && mph[c] < (mN[c] + 1) / 2;
            e_pend[c] = mpf[c];
        end
        m_run = rel0;
    endtask

    always @(posedge clk) begin
        if (n_reset) model_step();
    end

    task automatic compare_all();
        chk("n_rst_out", 32'(n_rst_out), 32'(m_rel));
        chk("clk_out", 32'(clk_out), 32'(e_clk));
        chk("tick", 32'(tick), 32'(e_tick));
        chk("upd_pend", 32'(upd_pend), 32'(e_pend));
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic wr(int ch, int d);
        wr_en = 1'b1; wr_ch = CH_W'(ch); wr_div = DIV_W'(d);
        step();
        wr_en = 1'b0;
    endtask

    // steps until n_rst_out is seen high, counting on from k0
    task automatic wait_rise(input int k0, output int k);
        k = k0;
        for (int j = 0; j < 400; j++) begin
            if (n_rst_out) break;
            step();
            k++;
        end
    endtask

    // steps until tick[ch] is seen high, bounded
    task automatic tick_gap(int ch, output int g);
        g = 0;
        for (int j = 0; j < 40; j++) begin
            step();
            g++;
            if (tick[ch]) break;
        end
    endtask

    initial begin
        int k, g, both, nt[NCH], nh[NCH];
        model_reset();
        lock = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_n_rst_out", 32'(n_rst_out), 0);
        chk("rst_clk_out", 32'(clk_out), 0);
        chk("rst_tick", 32'(tick), 0);
        chk("rst_upd_pend", 32'(upd_pend), 0);

        // power-up with lock high from release
        n_reset = 1'b1;
        wait_rise(0, k);
        chk("powerup_rise_edge", k, 256);
        step();
        chk("powerup_tick", 32'(tick), 32'hF);
        chk("powerup_clk", 32'(clk_out), 32'hF);

        // glitch-free update: 6 then 4 written mid-period
        wr(0, 6);
        repeat (10) step();
        tick_gap(0, g);
        wr(0, 4);
        chk("pend_after_wr", 32'(upd_pend[0]), 1);
        tick_gap(0, g);
        chk("gap_old_period", g, 5);
        chk("pend_cleared", 32'(upd_pend[0]), 0);
        tick_gap(0, g);
        chk("gap_new_period", g, 4);

        // resync of N=3 and N=5
        wr(0, 3);
        wr(1, 5);
        repeat (17) step();
        resync = 1'b1;
        step();
        resync = 1'b0;
        chk("resync_coincident", 32'(tick[1:0]), 3);
        both = 0;
        for (int j = 1; j < 15; j++) begin
            step();
            if (tick[1:0] == 2'b11) both++;
        end
        chk("resync_no_early", both, 0);
        step();
        chk("resync_15", 32'(tick[1:0]), 3);
        repeat (4) step();
        resync = 1'b1; wr_en = 1'b1; wr_ch = 3'd1; wr_div = 8'd5;
        step();
        resync = 1'b0; wr_en = 1'b0;
        chk("resync_wr_tick", 32'(tick[1:0]), 3);
        chk("resync_wr_pend", 32'(upd_pend[1]), 1);

        // single-cycle lock loss
        repeat (3) step();
        lock = 1'b0;
        step();
        lock = 1'b1;
`ifdef CLKDIV_LOCK_REARM_EN
        chk("lockloss_drop", 32'(n_rst_out), 0);
        step();
        chk("lockloss_hold_clk", 32'(clk_out), 0);
        chk("lockloss_hold_tick", 32'(tick), 0);
        wait_rise(1, k);
        chk("lockloss_rearm_edge", k, 256);
`else
        chk("lockloss_stays", 32'(n_rst_out), 1);
        step();
        chk("lockloss_stays2", 32'(n_rst_out), 1);
`endif

        // randomized traffic
        for (int j = 0; j < 400; j++) begin
            wr_en  = ($urandom_range(0, 3) == 0);
            wr_ch  = CH_W'($urandom_range(0, 7));
            wr_div = DIV_W'($urandom_range(0, 9));
            resync = ($urandom_range(0, 39) == 0);
            lock   = ($urandom_range(0, 199) != 0);
            step();
        end
        wr_en = 1'b0; resync = 1'b0; lock = 1'b1;
        repeat (3) step();

        // asynchronous reset between edges
        #2 n_reset = 1'b0;
        model_reset();
        #1;
        chk("async_n_rst_out", 32'(n_rst_out), 0);
        chk("async_clk_out", 32'(clk_out), 0);
        chk("async_tick", 32'(tick), 0);
        chk("async_upd_pend", 32'(upd_pend), 0);
        @(negedge clk);
        @(negedge clk);
        n_reset = 1'b1;
        wr(5, 9);
        chk("wr_ch_out_of_range", 32'(upd_pend), 0);
        wr(1, 3);
        wr(2, 7);
        wr(3, 0);
        wait_rise(4, k);
        chk("rerelease_edge", k, 256);
        for (int c = 0; c < NCH; c++) begin nt[c] = 0; nh[c] = 0; end
        for (int j = 0; j < 42; j++) begin
            step();
            for (int c = 0; c < NCH; c++) begin
                nt[c] += int'(tick[c]);
                nh[c] += int'(clk_out[c]);
            end
        end
        chk("ticks_ch0", nt[0], 21);
        chk("ticks_ch1", nt[1], 14);
        chk("ticks_ch2", nt[2], 6);
        chk("ticks_ch3", nt[3], 0);
        chk("high_ch0", nh[0], 21);
        chk("high_ch1", nh[1], 28);
        chk("high_ch2", nh[2], 24);
        chk("high_ch3", nh[3], 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
